avalon_mem_tester: RTL and testbench
====================================

# avalon_mem_tester

Avalon-MM master that fills a word-addressed on-chip memory region with a known pattern, reads it back, and reports mismatches. It is the initiator end of the 32-bit on-chip RAM slave interface in the SOPC: it attaches to the fabric as a master and drives the RAM's address, byteenable, read and write signals. It serves as a board bring-up and self-test engine, started by a control register or a push-button.

## Interface
- `ADDR_W`, 13: word-address width; matches the 13-bit RAM address.
- `SEED`, 32'h1, LFSR seed; must be non-zero.
- `clk`  in  1: single clock; all logic is rising-edge.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: one-cycle pulse to begin a test; ignored while `busy`=1.
- `base_addr`  in  ADDR_W: first word address; sampled on `start`.
- `num_words`  in  ADDR_W+1: number of words to test; sampled on `start`.
- `busy`  out  1: high from the cycle after an accepted `start` until `done`.
- `done`  out  1: one-cycle pulse at the end of a test.
- `error`  out  1: sticky; set if any mismatch occurred in the last test.
- `err_count`  out  16: mismatch count; saturates at 16'hFFFF.
- `first_err_addr`  out  ADDR_W: word address of the first mismatch.
- `avm_address`  out  ADDR_W: word address.
- `avm_byteenable`  out  4: always 4'hF while a request is active.
- `avm_read` / `avm_write`  out  1 each: request strobes; never both high.
- `avm_writedata`  out  32: write data.
- `avm_readdata`  in  32: read data.
- `avm_readdatavalid`  in  1: read data qualifier.
- `avm_waitrequest`  in  1: slave stall.

## Operation
- FSM states and transitions:
  - IDLE –start→ WRITE. If `num_words`=0, go straight to FINISH instead.
  - WRITE: issues `num_words` writes at `base_addr+i` with data `P(i)`. After the last write is accepted → RD_REQ.
  - RD_REQ: holds `avm_read` until accepted → RD_WAIT.
  - RD_WAIT: on `avm_readdatavalid`, compares `avm_readdata` against `P(i)`. Goes → RD_REQ for the next word, or → FINISH after the last word.
  - FINISH: `done`=1 for one cycle → IDLE.
- Request acceptance: a request is accepted in a cycle where the strobe is high and `avm_waitrequest`=0. Address, data and strobe must stay stable while `avm_waitrequest`=1.
- Outstanding reads: one at a time. A `readdatavalid` received outside RD_WAIT is ignored.
- Address arithmetic is modulo 2^ADDR_W; regions that run past the top wrap to 0.
- Pattern `P(i)` is defined under Configuration. The generator restarts from its origin at the entry to WRITE and again at the entry to RD_REQ for i=0, so the write and read sequences are identical.
- Mismatch handling:
  - `err_count` increments, saturating at 16'hFFFF.
  - `error` is set.
  - `first_err_addr` is captured only on the first mismatch of the test.
- Status clearing: `err_count`, `error` and `first_err_addr` clear on an accepted `start`. Otherwise they hold after `done` until the next `start`.
- Reset values: every output is 0, and the FSM is in IDLE. A reset during a test drops `avm_read`/`avm_write` in the next cycle; no `done` is produced.

## Timing
- An accepted `start` in cycle N gives `busy`=1 and the first `avm_write` in cycle N+1.
- Write throughput: with `avm_waitrequest` held at 0, one write per cycle (back-to-back strobes).
- Read cost: at least 2 cycles per word (RD_REQ plus RD_WAIT). With fixed slave read latency L, each word costs 1+L cycles.
- Status update: the compare result is visible in `err_count`/`error` in the cycle after `readdatavalid`.
- `done` is asserted the cycle after the last compare. `busy` falls in the same cycle that `done` is high.
- For `num_words`=0: `start` in cycle N gives `done` in N+1, with no bus traffic and `error`=0.

## Configuration
- Macro `MEMTEST_LFSR_PATTERN_EN`:
  - Defined: `P(i)` is a 32-bit Galois LFSR (polynomial x^32+x^22+x^2+x+1) loaded with `SEED` and advanced once per accepted write or per compare.
  - Undefined: `P(i) = {~i[15:0], i[15:0]}`, where i is the word offset from `base_addr`. No LFSR logic is synthesised.

## Test plan
- Zero-wait RAM model, `base_addr`=0, `num_words`=16 → 16 consecutive write cycles, then 16 reads; `done` pulses once, `error`=0, `err_count`=0.
- RAM model that flips bit 0 at word 5, `num_words`=8 → `error`=1, `err_count`=1, `first_err_addr`=5.
- `avm_waitrequest` toggled randomly, including a 10-cycle stall on write 3 → address and data stay stable while stalled; all 8 words pass.
- `base_addr`=8190, `num_words`=4 → addresses 8190, 8191, 0, 1 are written and read; pass.
- `num_words`=0 → `done` one cycle after `start`; `avm_read` and `avm_write` are never asserted.
- `reset` asserted mid-write at word 3 → next cycle all outputs are 0 and the FSM is in IDLE. A following `start` with `num_words`=4 completes with `error`=0.

Source files
------------

// File: rtl/avalon_mem_tester.sv
// avalon_mem_tester: Avalon-MM master that writes a pattern over a RAM region, reads it back and counts mismatches.
// Build option MEMTEST_LFSR_PATTERN_EN selects a Galois LFSR pattern instead of the {~i,i} offset pattern.
module avalon_mem_tester #(
  parameter int          ADDR_W = 13,
  parameter logic [31:0] SEED   = 32'h1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_words,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [ADDR_W-1:0] avm_address,
  output logic [3:0]        avm_byteenable,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  input  logic              avm_waitrequest
);
  localparam logic [2:0] S_IDLE = 3'd0, S_WRITE = 3'd1, S_RD_REQ = 3'd2, S_RD_WAIT = 3'd3, S_FINISH = 3'd4;
  localparam logic [ADDR_W:0] ONE = 1;
  logic [2:0]        state;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W:0]   cnt, idx;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       pat;
  logic              last, start_acc, wr_acc, rd_acc, cmp;
  assign addr      = base + idx[ADDR_W-1:0];
  assign last      = idx == cnt - ONE;
  assign start_acc = state == S_IDLE && start;
  assign wr_acc    = state == S_WRITE && !avm_waitrequest;
  assign rd_acc    = state == S_RD_REQ && !avm_waitrequest;
  assign cmp       = state == S_RD_WAIT && avm_readdatavalid;
`ifdef MEMTEST_LFSR_PATTERN_EN
  logic [31:0] lfsr;
  assign pat = lfsr;
  // Restart at write entry and at read entry so both passes see the same sequence
  always_ff @(posedge clk) begin
    if (reset || start_acc || (wr_acc && last)) lfsr <= SEED;
    else if (wr_acc || cmp) lfsr <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);
  end
`else
  logic [15:0] i16;
  assign i16 = 16'(idx);
  assign pat = {~i16, i16};
`endif
  assign busy           = state == S_WRITE || state == S_RD_REQ || state == S_RD_WAIT;
  assign done           = state == S_FINISH;
  assign avm_write      = state == S_WRITE;
  assign avm_read       = state == S_RD_REQ;
  assign avm_address    = (avm_read || avm_write) ? addr : '0;
  assign avm_byteenable = (avm_read || avm_write) ? 4'hF : 4'h0;
  assign avm_writedata  = avm_write ? pat : 32'h0;
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      base           <= '0;
      cnt            <= '0;
      idx            <= '0;
      error          <= 1'b0;
      err_count      <= 16'h0;
      first_err_addr <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          base           <= base_addr;
          cnt            <= num_words;
          idx            <= '0;
          error          <= 1'b0;
          err_count      <= 16'h0;
          first_err_addr <= '0;
          state          <= num_words == '0 ? S_FINISH : S_WRITE;
        end
        S_WRITE: if (wr_acc) begin
          idx   <= last ? '0 : idx + ONE;
          state <= last ? S_RD_REQ : S_WRITE;
        end
        S_RD_REQ: if (rd_acc) state <= S_RD_WAIT;
        S_RD_WAIT: if (cmp) begin
          idx   <= idx + ONE;
          state <= last ? S_FINISH : S_RD_REQ;
          if (avm_readdata != pat) begin
            err_count <= err_count + {15'h0, ~&err_count};
            error     <= 1'b1;
            if (!error) first_err_addr <= addr;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_avalon_mem_tester.sv
// tb_avalon_mem_tester: table-driven checks of the memory tester against a behavioural RAM with latency, stalls and faults.
module tb_avalon_mem_tester;
  logic        clk = 0, reset = 1, start = 0;
  logic [12:0] base_addr = 0;
  logic [13:0] num_words = 0;
  logic        busy, done, error;
  logic [15:0] err_count;
  logic [12:0] first_err_addr, avm_address;
  logic [3:0]  avm_byteenable;
  logic        avm_read, avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata = 0;
  logic        avm_readdatavalid = 0;
  logic        avm_waitrequest;
  logic        force_wait = 0, rand_wait = 0, wait_rand_en = 0;
  int          lat = 1, fault_mode = 0;
  logic [12:0] fault_addr = 0;
  logic [31:0] mem [8192];
  int          pend = 0;
  logic [31:0] pdata = 0;
  int wr_tot = 0, rd_tot = 0, done_tot = 0, both_tot = 0, busy_tot = 0, whi_tot = 0;
  int errors = 0, checks = 0;

  avalon_mem_tester dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_words(num_words),
    .busy(busy), .done(done), .error(error), .err_count(err_count), .first_err_addr(first_err_addr),
    .avm_address(avm_address), .avm_byteenable(avm_byteenable), .avm_read(avm_read),
    .avm_write(avm_write), .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .avm_waitrequest(avm_waitrequest)
  );

  always #5 clk = ~clk;
  assign avm_waitrequest = force_wait | rand_wait;

  always @(posedge clk) rand_wait <= wait_rand_en ? 1'($urandom_range(0, 1)) : 1'b0;

  // RAM model: read data returns lat+1 cycles after acceptance; faults corrupt bit 0 on readback only
  always @(posedge clk) begin
    avm_readdatavalid <= 1'b0;
    if (pend == 1) begin
      avm_readdatavalid <= 1'b1;
      avm_readdata      <= pdata;
    end
    if (pend != 0) pend <= pend - 1;
    if (avm_write && !avm_waitrequest) mem[avm_address] <= avm_writedata;
    if (avm_read && !avm_waitrequest) begin
      pend  <= lat;
      pdata <= mem[avm_address] ^ {31'h0, fault_mode == 2 || (fault_mode == 1 && avm_address == fault_addr)};
    end
  end

  always @(posedge clk) begin
    if (avm_write && !avm_waitrequest) wr_tot <= wr_tot + 1;
    if (avm_read && !avm_waitrequest) rd_tot <= rd_tot + 1;
    if (done) done_tot <= done_tot + 1;
    if (avm_read && avm_write) both_tot <= both_tot + 1;
    if (busy) busy_tot <= busy_tot + 1;
    if (avm_write) whi_tot <= whi_tot + 1;
  end

  function automatic logic [31:0] pat(int i);
    logic [31:0] l;
`ifdef MEMTEST_LFSR_PATTERN_EN
    l = 32'h1;
    for (int k = 0; k < i; k++) l = {1'b0, l[31:1]} ^ (l[0] ? 32'h8020_0003 : 32'h0);
`else
    logic [15:0] x;
    x = 16'(i);
    l = {~x, x};
`endif
    return l;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("done_timeout", 32'(t < 5000), 1);
    @(negedge clk);
  endtask

  task automatic kick(input logic [12:0] b, input logic [13:0] n);
    @(negedge clk);
    start = 1; base_addr = b; num_words = n;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_write(input logic [12:0] a);
    int t = 0;
    while (!(avm_write && avm_address == a) && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("write_seen", 32'(t < 500), 1);
  endtask

  typedef struct {
    logic [12:0] b;
    logic [13:0] n;
    int          fm;
    logic [12:0] fa;
    int          lt;
    bit          rnd;
    logic        e;
    logic [15:0] ec;
    logic [12:0] fe;
  } vec_t;
  vec_t tbl[6];

  initial begin
    int w0, r0, d0, b0, bs0, h0, bad;
    logic [12:0] a0;
    logic [31:0] wd0;
    tbl[0] = '{13'd0,    14'd16, 0, 13'd0, 1, 1'b0, 1'b0, 16'd0, 13'd0};
    tbl[1] = '{13'd0,    14'd8,  1, 13'd5, 1, 1'b0, 1'b1, 16'd1, 13'd5};
    tbl[2] = '{13'd8190, 14'd4,  0, 13'd0, 2, 1'b1, 1'b0, 16'd0, 13'd0};
    tbl[3] = '{13'd20,   14'd6,  2, 13'd0, 1, 1'b0, 1'b1, 16'd6, 13'd20};
    tbl[4] = '{13'd300,  14'd8,  0, 13'd0, 1, 1'b1, 1'b0, 16'd0, 13'd0};
    tbl[5] = '{13'd8191, 14'd3,  1, 13'd1, 3, 1'b0, 1'b1, 16'd1, 13'd1};
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_bus", {avm_read, avm_write, avm_byteenable, 13'(avm_address)}, 0);
    chk("rst_status", {error, err_count, first_err_addr}, 0);
    reset = 0;

    foreach (tbl[v]) begin
      lat = tbl[v].lt; fault_mode = tbl[v].fm; fault_addr = tbl[v].fa; wait_rand_en = tbl[v].rnd;
      w0 = wr_tot; r0 = rd_tot; d0 = done_tot; b0 = both_tot; bs0 = busy_tot; h0 = whi_tot;
      kick(tbl[v].b, tbl[v].n);
      wait_done();
      wait_rand_en = 0;
      chk($sformatf("v%0d_error", v), 32'(error), 32'(tbl[v].e));
      chk($sformatf("v%0d_err_count", v), 32'(err_count), 32'(tbl[v].ec));
      chk($sformatf("v%0d_first_err", v), 32'(first_err_addr), 32'(tbl[v].fe));
      chk($sformatf("v%0d_done_pulses", v), done_tot - d0, 1);
      chk($sformatf("v%0d_writes", v), wr_tot - w0, 32'(tbl[v].n));
      chk($sformatf("v%0d_reads", v), rd_tot - r0, 32'(tbl[v].n));
      chk($sformatf("v%0d_both", v), both_tot - b0, 0);
      chk($sformatf("v%0d_busy_after", v), 32'(busy), 0);
      bad = 0;
      for (int i = 0; i < int'(tbl[v].n); i++)
        if (mem[13'(int'(tbl[v].b) + i)] !== pat(i)) bad++;
      chk($sformatf("v%0d_mem", v), bad, 0);
      if (!tbl[v].rnd) begin
        chk($sformatf("v%0d_write_cycles", v), whi_tot - h0, 32'(tbl[v].n));
        chk($sformatf("v%0d_busy_cycles", v), busy_tot - bs0, 32'(int'(tbl[v].n) * (tbl[v].lt + 3)));
      end
      repeat (2) @(negedge clk);
    end
    fault_mode = 0; lat = 1;

    // start-to-first-write latency and back-to-back writes
    kick(13'd40, 14'd2);
    chk("t_busy", 32'(busy), 1);
    chk("t_write0", {avm_write, avm_byteenable, 19'h0, avm_address}, {1'b1, 4'hF, 19'h0, 13'd40});
    chk("t_wdata0", avm_writedata, pat(0));
    @(negedge clk);
    chk("t_write1", {avm_write, 18'h0, avm_address}, {1'b1, 18'h0, 13'd41});
    chk("t_wdata1", avm_writedata, pat(1));
    wait_done();
    chk("t_error", 32'(error), 0);

    // zero-length test
    w0 = wr_tot; r0 = rd_tot; h0 = whi_tot;
    kick(13'd7, 14'd0);
    chk("z_done", 32'(done), 1);
    chk("z_busy", 32'(busy), 0);
    @(negedge clk);
    chk("z_done_low", 32'(done), 0);
    chk("z_traffic", (wr_tot - w0) + (rd_tot - r0) + (whi_tot - h0), 0);
    chk("z_error", 32'(error), 0);

    // 10-cycle stall on write 3, then random waits
    w0 = wr_tot;
    kick(13'd100, 14'd8);
    wait_write(13'd103);
    force_wait = 1;
    a0 = avm_address; wd0 = avm_writedata;
    chk("s_addr", 32'(a0), 103);
    chk("s_data", wd0, pat(3));
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!avm_write || avm_address !== a0 || avm_writedata !== wd0) bad++;
    end
    force_wait = 0; wait_rand_en = 1;
    wait_done();
    wait_rand_en = 0;
    chk("s_stable", bad, 0);
    chk("s_error", 32'(error), 0);
    chk("s_writes", wr_tot - w0, 8);

    // reset mid-write then a clean run
    d0 = done_tot;
    kick(13'd0, 14'd8);
    wait_write(13'd3);
    reset = 1;
    @(negedge clk);
    chk("r_bus", {avm_read, avm_write, avm_byteenable, 13'(avm_address)}, 0);
    chk("r_wdata", avm_writedata, 0);
    chk("r_flags", {busy, done, error}, 0);
    reset = 0;
    @(negedge clk);
    chk("r_no_done", done_tot - d0, 0);
    kick(13'd0, 14'd4);
    wait_done();
    chk("r2_error", 32'(error), 0);
    chk("r2_count", 32'(err_count), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
